// File: rtl/if_id_buf_pkg.sv
// Shared fetch/decode constants for the instruction buffer between IF and ID.
package if_id_buf_pkg;

    localparam int unsigned INST_ADDR_BUS = 32;
    localparam int unsigned INST_DATA_BUS = 32;

    // addi x0, x0, 0 -- presented to decode whenever the buffer is empty
    localparam logic [31:0] NOP_INST = 32'h0000_0013;

endpackage

// File: rtl/fifo_ptr.sv
// Wrap-bit pointer counter: the MSB toggles each pass so equal indices can be
// told apart as full or empty.
module fifo_ptr #(
    parameter int unsigned PTR_W = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc_i,
    input  logic             clr_i,
    output logic [PTR_W-1:0] ptr_o
);

    logic [PTR_W-1:0] ptr_q, ptr_d;

    always_comb begin
        ptr_d = ptr_q;
        if (clr_i) begin
            ptr_d = '0;
        end else if (inc_i) begin
            ptr_d = ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ptr_q <= '0;
        end else begin
            ptr_q <= ptr_d;
        end
    end

    assign ptr_o = ptr_q;

endmodule

// File: rtl/if_id_buf.sv
// Fetch-to-decode instruction FIFO with valid/ready on both sides and a
// single-cycle flush for branch redirects.
module if_id_buf
    import if_id_buf_pkg::*;
#(
    parameter int unsigned DEPTH  = 2,
    parameter int unsigned ADDR_W = INST_ADDR_BUS,
    parameter int unsigned DATA_W = INST_DATA_BUS
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     valid_pre_i,
    output logic                     ready_pre_o,
    input  logic [ADDR_W-1:0]        pc_i,
    input  logic [DATA_W-1:0]        inst_i,
    output logic                     valid_post_o,
    input  logic                     ready_post_i,
    output logic [ADDR_W-1:0]        pc_o,
    output logic [DATA_W-1:0]        inst_o,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int unsigned IDX_W = $clog2(DEPTH);
    localparam int unsigned PTR_W = IDX_W + 1;

    logic [ADDR_W-1:0] pc_mem   [DEPTH];
    logic [DATA_W-1:0] inst_mem [DEPTH];

    logic [PTR_W-1:0] rptr, wptr;
    logic [IDX_W-1:0] ridx, widx;
    logic             empty, full;
    logic             push, pop;

    assign ridx = rptr[IDX_W-1:0];
    assign widx = wptr[IDX_W-1:0];

    assign empty = (rptr == wptr);
    assign full  = (ridx == widx) && (rptr[IDX_W] != wptr[IDX_W]);

    // ready depends only on stored state, so a same-cycle pop never frees a slot
    assign ready_pre_o  = !full;
    assign valid_post_o = !empty;

    assign push = valid_pre_i && ready_pre_o && !flush_i;
    assign pop  = valid_post_o && ready_post_i && !flush_i;

    fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_rptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (pop),
        .clr_i (flush_i),
        .ptr_o (rptr)
    );

    fifo_ptr #(
        .PTR_W (PTR_W)
    ) u_wptr (
        .clk   (clk),
        .rst   (rst),
        .inc_i (push),
        .clr_i (flush_i),
        .ptr_o (wptr)
    );

    // Storage is never cleared; the pointers alone decide what is live.
    always_ff @(posedge clk) begin
        if (push) begin
            pc_mem[widx]   <= pc_i;
            inst_mem[widx] <= inst_i;
        end
    end

    always_comb begin
        pc_o   = '0;
        inst_o = DATA_W'(NOP_INST);
        if (!empty) begin
            pc_o   = pc_mem[ridx];
            inst_o = inst_mem[ridx];
        end
    end

    assign count_o = wptr - rptr;

endmodule

// File: tb/tb_if_id_buf.sv
// Self-checking bench for if_id_buf: directed scenarios followed by random
// traffic, all compared against a queue-based model of the buffer.
module tb_if_id_buf;

    localparam int unsigned DEPTH = 2;
    localparam int unsigned CW    = $clog2(DEPTH) + 1;

    logic          clk = 1'b0;
    logic          rst;
    logic          valid_pre_i;
    logic          ready_pre_o;
    logic [31:0]   pc_i;
    logic [31:0]   inst_i;
    logic          valid_post_o;
    logic          ready_post_i;
    logic [31:0]   pc_o;
    logic [31:0]   inst_o;
    logic          flush_i;
    logic [CW-1:0] count_o;

    int n_vec = 0;
    int n_err = 0;

    logic [63:0] model_q [$];

    if_id_buf #(
        .DEPTH  (DEPTH),
        .ADDR_W (32),
        .DATA_W (32)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .valid_pre_i  (valid_pre_i),
        .ready_pre_o  (ready_pre_o),
        .pc_i         (pc_i),
        .inst_i       (inst_i),
        .valid_post_o (valid_post_o),
        .ready_post_i (ready_post_i),
        .pc_o         (pc_o),
        .inst_o       (inst_o),
        .flush_i      (flush_i),
        .count_o      (count_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp)
        else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        head = (model_q.size() > 0) ? model_q[0] : {32'h0, 32'h0000_0013};
        chk("valid_post", {31'b0, valid_post_o}, {31'b0, model_q.size() > 0});
        chk("ready_pre",  {31'b0, ready_pre_o},  {31'b0, model_q.size() < DEPTH});
        chk("count",      32'(count_o),          32'(model_q.size()));
        chk("pc_o",       pc_o,                  head[63:32]);
        chk("inst_o",     inst_o,                head[31:0]);
    endtask

    // Apply one cycle of inputs, check pre-edge outputs, then advance the model.
    task automatic cycle(input logic vp, input logic [31:0] p, input logic [31:0] in,
                         input logic rp, input logic fl, input logic rs);
        logic do_push, do_pop;
        valid_pre_i  = vp;
        pc_i         = p;
        inst_i       = in;
        ready_post_i = rp;
        flush_i      = fl;
        rst          = rs;
        #1;
        check_outputs();
        do_push = vp && (model_q.size() < DEPTH) && !fl;
        do_pop  = (model_q.size() > 0) && rp && !fl;
        @(posedge clk);
        if (rs || fl) begin
            model_q.delete();
        end else begin
            if (do_pop) void'(model_q.pop_front());
            if (do_push) model_q.push_back({p, in});
        end
        #1;
    endtask

    initial begin
        logic        vp, rp, fl, rs, hold;
        logic [31:0] p, in;
        int          idx;

        valid_pre_i  = 1'b0;
        pc_i         = '0;
        inst_i       = '0;
        ready_post_i = 1'b0;
        flush_i      = 1'b0;
        rst          = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset then idle
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Fill to full with decode stalled, then a refused third push
        cycle(1'b1, 32'h8000_0000, 32'h0000_0297, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h8000_0004, 32'h0000_0317, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h8000_0008, 32'h0000_0393, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h8000_0008, 32'h0000_0393, 1'b0, 1'b0, 1'b0);

        // Full: pop succeeds, push refused; then both succeed
        cycle(1'b1, 32'h8000_0008, 32'h0000_0393, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 32'h8000_0008, 32'h0000_0393, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Stream 8 sequential pcs with decode always ready
        idx = 0;
        while (idx < 8) begin
            p = 32'h8000_0000 + 32'(idx * 4);
            hold = model_q.size() >= DEPTH;
            cycle(1'b1, p, 32'h0010_0093 + 32'(idx), 1'b1, 1'b0, 1'b0);
            if (!hold) idx++;
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);

        // Flush at count 2 alongside push and pop, then a fresh push
        cycle(1'b1, 32'h8000_0040, 32'h0000_0001, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h8000_0044, 32'h0000_0002, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 32'h8000_0048, 32'h0000_0003, 1'b1, 1'b1, 1'b0);
        cycle(1'b1, 32'h8000_0100, 32'h0000_0004, 1'b0, 1'b0, 1'b0);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Reset with an entry held and a push pending
        cycle(1'b1, 32'h8000_0200, 32'h0000_0005, 1'b0, 1'b0, 1'b1);
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        // Random traffic; upstream holds its pair while refused
        hold = 1'b0;
        vp   = 1'b0;
        p    = '0;
        in   = '0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                vp = 1'($urandom_range(0, 2) != 0);
                p  = $urandom;
                in = $urandom;
            end
            rp = 1'($urandom_range(0, 2) != 0);
            fl = 1'($urandom_range(0, 15) == 0);
            rs = 1'($urandom_range(0, 63) == 0);
            hold = vp && (model_q.size() >= DEPTH) && !fl && !rs;
            cycle(vp, p, in, rp, fl, rs);
        end
        cycle(1'b0, 32'h0, 32'h0, 1'b0, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/if_id_buf.md
# if_id_buf

Instruction buffer between the fetch stage and the decode stage. Accepts fetched (pc, instruction) pairs over a valid/ready handshake, holds up to DEPTH of them in FIFO order, and presents the head entry to decode over a second valid/ready handshake. A branch redirect flushes all buffered entries in one cycle. Fetch latency is decoupled from decode stalls.

## Interface
- DEPTH, 2, number of entries; power of two, ≥2
- ADDR_W, 32, pc width (`INST_ADDR_BUS`)
- DATA_W, 32, instruction width (`INST_DATA_BUS`)

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  reset; synchronous, active-high
- valid_pre_i  in  1  fetch presents a valid pair
- ready_pre_o  out  1  buffer can accept a pair this cycle
- pc_i  in  ADDR_W  pc of fetched instruction
- inst_i  in  DATA_W  fetched instruction
- valid_post_o  out  1  head entry valid for decode
- ready_post_i  in  1  decode accepts head entry
- pc_o  out  ADDR_W  head pc
- inst_o  out  DATA_W  head instruction
- flush_i  in  1  branch redirect; discard all contents
- count_o  out  log2(DEPTH)+1  current occupancy

## Operation
- Storage: DEPTH-entry array of {pc, inst}; read pointer rptr, write pointer wptr, each log2(DEPTH)+1 bits (extra wrap bit).
- empty = (rptr == wptr); full = index bits equal and wrap bits differ.
- count_o = wptr − rptr, modulo 2^(log2(DEPTH)+1).
- push = valid_pre_i & ready_pre_o & !flush_i: write {pc_i, inst_i} at wptr index, wptr+1.
- pop = valid_post_o & ready_post_i & !flush_i: rptr+1.
- ready_pre_o = !full. A pop in the same cycle does not raise ready; no combinational path from ready_post_i to ready_pre_o.
- valid_post_o = !empty. pc_o/inst_o = entry at rptr when not empty; when empty, pc_o = 0 and inst_o = `NOP_INST` (32'h0000_0013).
- Simultaneous push and pop when neither empty nor full: both take effect; count unchanged.
- Push while empty: the entry becomes visible the next cycle (no bypass).
- Pointers wrap naturally at 2^(log2(DEPTH)+1); the index uses the low log2(DEPTH) bits.
- flush_i: rptr and wptr both reset to 0 at the next edge; any push or pop in the same cycle is ignored. Array contents are not cleared.
- rst has priority over flush_i. Mid-operation reset discards all entries.

## Timing
- Reset values:
  - valid_post_o 0
  - ready_pre_o 1
  - count_o 0
  - pc_o 0
  - inst_o 32'h0000_0013
- Latency from push to valid_post_o is 1 cycle. Throughput is 1 pair per cycle in steady state with DEPTH ≥ 2.
- The cycle after a flush:
  - valid_post_o = 0
  - ready_pre_o = 1
- Handshake rules:
  - Once valid_post_o is 1, pc_o/inst_o stay stable until a pop, flush, or reset.
  - Upstream holds pc_i/inst_i stable while valid_pre_i=1 and ready_pre_o=0.
- All outputs are functions of registered state only. No input-to-output combinational paths.

## Structure
- The shared defines header holds `INST_ADDR_BUS`, `INST_DATA_BUS`, and a new `NOP_INST` (32'h0000_0013).
- One sub-module, `fifo_ptr`: a wrap-bit pointer counter with inc and clr inputs, instantiated twice (rptr, wptr). Full/empty compare and storage stay in the top.
- The branch-redirect signal that drives the fetch stage's next-pc select also drives flush_i.

## Test plan
- Reset then idle:
  - ready_pre_o=1, valid_post_o=0, count_o=0, inst_o=32'h0000_0013.
- Push pc=0x8000_0000, inst=0x0000_0297, with ready_post_i=0:
  - Next cycle: valid_post_o=1, pc_o=0x8000_0000, count_o=1.
  - Push a second pair; after that edge count_o=2 and ready_pre_o=0.
  - A third valid_pre_i is not accepted; the head is unchanged.
- Buffer full (DEPTH=2), assert ready_post_i and valid_pre_i together:
  - Pop occurs, push is refused (ready_pre_o was 0), count_o=1.
  - Next cycle both succeed and count_o stays 1.
- Stream 8 sequential pcs 0x8000_0000..0x8000_001C with ready_post_i=1 every cycle:
  - Output order matches input order, one per cycle after the first.
  - Pointers wrap twice with no loss.
- count_o=2, assert flush_i together with valid_pre_i=1 and ready_post_i=1:
  - Next cycle valid_post_o=0 and count_o=0; the pushed pair is dropped.
  - A following push of pc=0x8000_0100 appears as the head.
- Assert rst while holding 1 entry and valid_pre_i=1:
  - Next cycle all outputs are at reset values and the pending push is discarded.
